fp_sum_sched: RTL
=================

Name: fp_sum_sched

Overview:
- Round-robin scheduler that shares one registered fixed-point adder between N_REQ requesters.
- Each requester presents operand pair A (S(NB_A,NBF_A)) and B (S(NB_B,NBF_B)) with valid/ready.
- The block grants one requester, aligns and adds the operands at full resolution, and reduces the result to S(NB_OUT,NBF_OUT) per i_mode.
- The result is held with the requester ID until the downstream consumer accepts it. The block sits between multi-channel filter taps and the shared output stage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- NB_A, 16, total bits of A. NBF_A, 14, fractional bits of A.
- NB_B, 12, total bits of B. NBF_B, 11, fractional bits of B.
- NB_OUT, 11, total bits of reduced output. NBF_OUT, 10, fractional bits of output (NBF_OUT < max(NBF_A,NBF_B)).
- Derived localparams: NBF_FR = max(NBF_A,NBF_B); NBI_FR = max(NB_A-NBF_A, NB_B-NBF_B)+1; NB_FR = NBI_FR+NBF_FR (17 with defaults); NB_ID = clog2(N_REQ).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  N_REQ  per-requester operand valid.
- i_a  in  N_REQ*NB_A  packed A operands; requester k at [k*NB_A +: NB_A].
- i_b  in  N_REQ*NB_B  packed B operands; same packing.
- o_ready  out  N_REQ  one-hot grant pulse; operands of requester k consumed when i_valid[k]&o_ready[k].
- i_mode  in  2  reduction mode, sampled at grant: 0 trunc-wrap, 1 trunc-sat, 2/3 round-sat.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accept.
- o_id  out  NB_ID  granted requester index.
- o_sum_fr  out  NB_FR  full-resolution sum S(NB_FR,NBF_FR).
- o_sum  out  NB_OUT  reduced sum.
- o_sat  out  1  reduction clipped (modes 1-3) or wrapped (mode 0).
- i_clr_stats  in  1  clear statistics counter (feature only).
- o_sat_cnt  out  16  saturation event count (feature only).

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, RR pointer=0, o_ready=0, o_valid=0, o_id=0, o_sum_fr=0, o_sum=0, o_sat=0, o_sat_cnt=0. Any in-flight result is discarded.
- FSM IDLE:
  - If |i_valid, pick the first asserted index searching from the pointer upward with wrap.
  - Assert o_ready[g] combinationally for this cycle only.
  - Latch A, B, g, i_mode. Next state EXEC.
  - If no valid, stay in IDLE.
- FSM EXEC: compute full-resolution sum and reduction, register all outputs, set o_valid=1. Next state HOLD.
- FSM HOLD:
  - o_valid=1; o_id, o_sum_fr, o_sum and o_sat stay stable.
  - On i_ready: o_valid=0 next cycle, pointer=(g+1) mod N_REQ, next state IDLE.
  - No grant is issued in HOLD, even when i_ready and i_valid coincide.
- Timing: latency grant-to-o_valid is 2 cycles. Minimum spacing between grants is 3 cycles.
- Requester rule: the requester holds i_valid and operands stable until it sees o_ready. Dropping i_valid before grant is allowed and causes no grant.
- Arithmetic, full resolution:
  - Left-shift the operand with fewer fractional bits by |NBF_A-NBF_B|.
  - Sign-extend both operands to NB_FR and add. No overflow is possible.
- Reduction:
  - Let D = NBF_FR-NBF_OUT.
  - Truncation drops the D LSBs.
  - Rounding adds 1 at bit D-1 (round half up, toward +inf) in a 1-bit-wider sum, then drops the D LSBs.
  - Overflow check: the bits above the output MSB must all equal the output sign bit.
  - Mode 0: wrap, i.e. keep the low NB_OUT bits.
  - Modes 1-3: on overflow, output 0x3FF-style max positive (0 followed by all ones) or min negative (1 followed by all zeros), chosen by the sign of the pre-reduction value.
  - o_sat=1 whenever the overflow check fails, in any mode.
- Pointer: advances only on acceptance (IDLE entry from HOLD), never on reset release.

Optional Feature:
- FP_SUM_SCHED_STATS_EN defined: o_sat_cnt increments by 1 at each EXEC cycle where the reduction overflows. It saturates at 0xFFFF and clears synchronously when i_clr_stats=1; clear wins over increment.
- Not defined: o_sat_cnt is driven to 0 and i_clr_stats is ignored; no counter logic is synthesized.

Test Plan:
- Requester 0, mode 1, A=0x2000 (0.5), B=0x200 (0.25): o_ready[0] pulses, o_valid 2 cycles later; o_sum_fr=0x03000, o_sum=0x300 (0.75), o_sat=0, o_id=0.
- Requester 1, A=0x6000 (1.5), B=0x600 (0.75): o_sum_fr=0x09000. Mode 1 gives o_sum=0x3FF, o_sat=1. Mode 0 gives o_sum=0x100, o_sat=1.
- Requester 2, mode 1, A=0x8000 (-2.0), B=0x800 (-1.0): o_sum_fr=0x14000, o_sum=0x400, o_sat=1.
- Rounding:
  - A=0x0008, B=0: mode 2 gives o_sum=0x001; mode 1 gives 0x000.
  - A=0x3FFF, B=0: mode 2 gives o_sum=0x3FF, o_sat=1.
- All 4 i_valid held high after reset, i_ready=1: grants in order 0,1,2,3,0, each 3 cycles apart. With i_ready=0 for 5 cycles in HOLD, outputs stay stable and no o_ready is asserted.
- Reset and statistics:
  - Assert i_rst_n=0 during EXEC: all outputs 0 immediately; after release, first grant goes to requester 0.
  - With FP_SUM_SCHED_STATS_EN defined: 3 saturating ops give o_sat_cnt=3; i_clr_stats then gives 0.

Source files
------------

// File: rtl/fp_sum_sched_if.sv
// Operand / result handshake bundle for fp_sum_sched.
//   Requester side : i_valid, i_a, i_b (packed per requester), o_ready (one-hot grant)
//   Consumer side  : o_valid, i_ready, o_id, o_sum_fr, o_sum, o_sat
// Modports: slave = the scheduler, master = requesters + downstream consumer.
interface fp_sum_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned NB_A  = 16,
  parameter int unsigned NBF_A = 14,
  parameter int unsigned NB_B  = 12,
  parameter int unsigned NBF_B = 11,
  parameter int unsigned NB_OUT = 11
);
  localparam int unsigned NBF_FR = (NBF_A > NBF_B) ? NBF_A : NBF_B;
  localparam int unsigned NBI_FR = (((NB_A - NBF_A) > (NB_B - NBF_B)) ?
                                    (NB_A - NBF_A) : (NB_B - NBF_B)) + 1;
  localparam int unsigned NB_FR  = NBI_FR + NBF_FR;
  localparam int unsigned NB_ID  = $clog2(N_REQ);

  logic [N_REQ-1:0]      i_valid;
  logic [N_REQ*NB_A-1:0] i_a;
  logic [N_REQ*NB_B-1:0] i_b;
  logic [N_REQ-1:0]      o_ready;
  logic                  o_valid;
  logic                  i_ready;
  logic [NB_ID-1:0]      o_id;
  logic [NB_FR-1:0]      o_sum_fr;
  logic [NB_OUT-1:0]     o_sum;
  logic                  o_sat;

  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_id, o_sum_fr, o_sum, o_sat
  );

  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_id, o_sum_fr, o_sum, o_sat
  );
endinterface

// File: rtl/fp_sum_sched.sv
// Round-robin scheduler sharing one registered fixed-point adder among N_REQ
// requesters. A granted pair A S(NB_A,NBF_A) + B S(NB_B,NBF_B) is aligned,
// added at full resolution S(NB_FR,NBF_FR) and reduced to S(NB_OUT,NBF_OUT)
// (mode 0 trunc-wrap, 1 trunc-sat, 2/3 round-half-up-sat). The result is held
// with the requester id until the consumer accepts it.
// Ports:
//   i_clk, i_rst_n  clock (rising edge), async active-low reset
//   bus             fp_sum_sched_if.slave: operand/grant and result handshakes
//   i_mode          reduction mode, sampled at grant
//   i_clr_stats     synchronous clear of o_sat_cnt
//   o_sat_cnt       count of overflowing reductions (saturates at 0xFFFF)
// Build option: define FP_SUM_SCHED_STATS_EN to include the overflow counter;
// otherwise o_sat_cnt is tied to zero and i_clr_stats is ignored.
module fp_sum_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned NB_A    = 16,
  parameter int unsigned NBF_A   = 14,
  parameter int unsigned NB_B    = 12,
  parameter int unsigned NBF_B   = 11,
  parameter int unsigned NB_OUT  = 11,
  parameter int unsigned NBF_OUT = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  fp_sum_sched_if.slave       bus,
  input  logic [1:0]          i_mode,
  input  logic                i_clr_stats,
  output logic [15:0]         o_sat_cnt
);
  localparam int unsigned NBF_FR = (NBF_A > NBF_B) ? NBF_A : NBF_B;
  localparam int unsigned NBI_FR = (((NB_A - NBF_A) > (NB_B - NBF_B)) ?
                                    (NB_A - NBF_A) : (NB_B - NBF_B)) + 1;
  localparam int unsigned NB_FR  = NBI_FR + NBF_FR;
  localparam int unsigned NB_ID  = $clog2(N_REQ);
  localparam int unsigned D      = NBF_FR - NBF_OUT;
  localparam int unsigned NB_RD  = NB_FR + 1 - D;
  localparam int unsigned SH_A   = NBF_FR - NBF_A;
  localparam int unsigned SH_B   = NBF_FR - NBF_B;

  localparam logic [NB_ID:0]   N_REQ_W = (NB_ID + 1)'(N_REQ);
  localparam logic [NB_ID-1:0] LAST_ID = NB_ID'(N_REQ - 1);
  localparam logic [NB_FR:0]   HALF    = (NB_FR + 1)'(1) << (D - 1);
  localparam logic [NB_OUT-1:0] OUT_MAX = {1'b0, {(NB_OUT - 1){1'b1}}};
  localparam logic [NB_OUT-1:0] OUT_MIN = {1'b1, {(NB_OUT - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            state, state_nxt;
  logic [NB_ID-1:0]  ptr;
  logic [NB_ID-1:0]  gnt_idx;
  logic              gnt_any;
  logic [NB_ID:0]    idx_w;
  logic [N_REQ-1:0]  ready_c;

  logic [NB_A-1:0]   a_q;
  logic [NB_B-1:0]   b_q;
  logic [NB_ID-1:0]  id_q;
  logic [1:0]        mode_q;

  logic signed [NB_FR-1:0] a_al, b_al, sum_fr;
  logic [NB_RD-1:0]  rnd_hi, red;
  logic [NB_RD-NB_OUT:0] top;
  logic              ovf;
  logic [NB_OUT-1:0] sum_red;

  logic              valid_q, sat_q;
  logic [NB_ID-1:0]  id_out_q;
  logic [NB_FR-1:0]  sum_fr_q;
  logic [NB_OUT-1:0] sum_q;

  // First asserted valid at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_w   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_w = {1'b0, ptr} + (NB_ID + 1)'(i);
      if (idx_w >= N_REQ_W) idx_w = idx_w - N_REQ_W;
      if (!gnt_any && bus.i_valid[idx_w[NB_ID-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w[NB_ID-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = '0;
    case (state)
      IDLE: if (gnt_any && i_rst_n) begin
        ready_c[gnt_idx] = 1'b1;
        state_nxt        = EXEC;
      end
      EXEC: state_nxt = HOLD;
      HOLD: if (bus.i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Alignment: sign-extend to NB_FR then shift the coarser operand up.
  assign a_al   = $signed({{(NB_FR - NB_A){a_q[NB_A-1]}}, a_q}) <<< SH_A;
  assign b_al   = $signed({{(NB_FR - NB_B){b_q[NB_B-1]}}, b_q}) <<< SH_B;
  assign sum_fr = a_al + b_al;

  // Both reduction paths are brought to a common NB_RD width (one bit wider
  // than truncation needs, so a rounding carry is never lost).
  assign rnd_hi = NB_RD'(({sum_fr[NB_FR-1], sum_fr} + HALF) >> D);
  assign red    = mode_q[1] ? rnd_hi : {sum_fr[NB_FR-1], sum_fr[NB_FR-1:D]};
  assign top    = red[NB_RD-1:NB_OUT-1];
  assign ovf    = ~((&top) | ~(|top));

  always_comb begin
    sum_red = red[NB_OUT-1:0];
    if (mode_q != 2'd0 && ovf) sum_red = sum_fr[NB_FR-1] ? OUT_MIN : OUT_MAX;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      mode_q   <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      id_out_q <= '0;
      sum_fr_q <= '0;
      sum_q    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          a_q    <= bus.i_a[gnt_idx*NB_A +: NB_A];
          b_q    <= bus.i_b[gnt_idx*NB_B +: NB_B];
          id_q   <= gnt_idx;
          mode_q <= i_mode;
        end
        EXEC: begin
          valid_q  <= 1'b1;
          id_out_q <= id_q;
          sum_fr_q <= sum_fr;
          sum_q    <= sum_red;
          sat_q    <= ovf;
        end
        HOLD: if (bus.i_ready) begin
          valid_q <= 1'b0;
          ptr     <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready  = ready_c;
  assign bus.o_valid  = valid_q;
  assign bus.o_id     = id_out_q;
  assign bus.o_sum_fr = sum_fr_q;
  assign bus.o_sum    = sum_q;
  assign bus.o_sat    = sat_q;

`ifdef FP_SUM_SCHED_STATS_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 sat_cnt_q <= '0;
    else if (i_clr_stats)                         sat_cnt_q <= '0;
    else if (state == EXEC && ovf && sat_cnt_q != '1) sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign o_sat_cnt = sat_cnt_q;
`else
  logic unused_clr_stats;
  assign unused_clr_stats = i_clr_stats;
  assign o_sat_cnt        = '0;
`endif
endmodule
